// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared definitions for the round-robin FIFO scheduler: default sizing and FSM state encodings.
package fifo_rr_scheduler_pkg;

   localparam int unsigned DEF_DATA_WIDTH  = 6;
   localparam int unsigned DEF_NUM_Q       = 4;
   localparam int unsigned DEF_DEST_LSB    = 4;
   localparam int unsigned DEF_INIT_CYCLES = 2;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_PAUSE  = 2'd3
   } state_t;

endpackage

// File: rtl/fifo_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr, searched modulo NUM_Q.
module rr_arbiter
   import fifo_rr_scheduler_pkg::*;
#(
   parameter int unsigned NUM_Q = DEF_NUM_Q,
   parameter int unsigned IDX_W = $clog2(NUM_Q)
) (
   input  logic [NUM_Q-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             en,
   output logic [NUM_Q-1:0] gnt,
   output logic [IDX_W-1:0] idx
);

   logic             found;
   logic [IDX_W-1:0] cand;

   // NUM_Q is a power of two, so the index wraps naturally; the last candidate is ptr itself
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned off = 1; off <= NUM_Q; off++) begin
         cand = ptr + IDX_W'(off);
         if (en && !found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin scheduler moving words from NUM_Q input FIFOs to NUM_Q output FIFOs by destination field.
module fifo_rr_scheduler
   import fifo_rr_scheduler_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned NUM_Q       = DEF_NUM_Q,
   parameter int unsigned DEST_LSB    = DEF_DEST_LSB,
   parameter int unsigned INIT_CYCLES = DEF_INIT_CYCLES
) (
   input  logic                        clk,
   input  logic                        reset_L,
   input  logic [NUM_Q-1:0]            in_empty,
   input  logic [NUM_Q*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_Q-1:0]            out_pause,
   input  logic [NUM_Q-1:0]            out_full,
   output logic [NUM_Q-1:0]            pop,
   output logic [NUM_Q-1:0]            push,
   output logic [DATA_WIDTH-1:0]       data_out,
   output logic [1:0]                  state,
   output logic                        idle,
   output logic                        error
);

   localparam int unsigned IDX_W = $clog2(NUM_Q);
   localparam int unsigned CNT_W = $clog2(INIT_CYCLES + 1);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        init_cnt;
   logic [IDX_W-1:0]        ptr;
   logic [IDX_W-1:0]        gidx, gidx2;
   logic                    vld, vld2;
   logic                    grant_en;
   logic [NUM_Q-1:0]        gnt;
   logic [IDX_W-1:0]        idx;
   logic [DATA_WIDTH-1:0]   word;
   logic [IDX_W-1:0]        dest;
   logic [NUM_Q-1:0]        push_d;

   assign grant_en = (state_q == ST_ACTIVE) && !(|out_pause);

   rr_arbiter #(
      .NUM_Q (NUM_Q),
      .IDX_W (IDX_W)
   ) u_arb (
      .req (~in_empty),
      .ptr (ptr),
      .en  (grant_en),
      .gnt (gnt),
      .idx (idx)
   );

   // The input FIFO answers one cycle after pop, so the word is sampled via the second stage
   assign word = in_data[gidx2 * DATA_WIDTH +: DATA_WIDTH];
   assign dest = word[DEST_LSB +: IDX_W];

   always_comb begin
      push_d       = '0;
      push_d[dest] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_INIT:   if (init_cnt == CNT_W'(INIT_CYCLES - 1)) state_d = ST_IDLE;
         ST_IDLE:   if (!(&in_empty)) state_d = ST_ACTIVE;
         ST_ACTIVE: begin
            if (|out_pause)                       state_d = ST_PAUSE;
            else if (&in_empty && !(vld || vld2)) state_d = ST_IDLE;
         end
         ST_PAUSE:  if (!(|out_pause)) state_d = (&in_empty) ? ST_IDLE : ST_ACTIVE;
         default:   state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q  <= ST_INIT;
         init_cnt <= '0;
         ptr      <= '1;
         pop      <= '0;
         gidx     <= '0;
         vld      <= 1'b0;
         gidx2    <= '0;
         vld2     <= 1'b0;
         push     <= '0;
         data_out <= '0;
         error    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_INIT) init_cnt <= init_cnt + 1'b1;
         pop <= gnt;
         vld <= |gnt;
         if (|gnt) begin
            gidx <= idx;
            ptr  <= idx;
         end
         vld2  <= vld;
         gidx2 <= gidx;
         push  <= vld2 ? push_d : '0;
         if (vld2) begin
            data_out <= word;
            if (out_full[dest]) error <= 1'b1;
         end
      end
   end

   assign state = state_q;
   assign idle  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Self-checking bench for fifo_rr_scheduler: behavioural input FIFOs plus a push scoreboard.
module tb_fifo_rr_scheduler;

   localparam int DW = 6;
   localparam int NQ = 4;

   logic             clk = 1'b0;
   logic             reset_L = 1'b0;
   logic [NQ-1:0]    in_empty = '1;
   logic [NQ*DW-1:0] in_data = '0;
   logic [NQ-1:0]    out_pause = '0;
   logic [NQ-1:0]    out_full = '0;
   logic [NQ-1:0]    pop;
   logic [NQ-1:0]    push;
   logic [DW-1:0]    data_out;
   logic [1:0]       state;
   logic             idle;
   logic             error;

   fifo_rr_scheduler #(
      .DATA_WIDTH  (DW),
      .NUM_Q       (NQ),
      .DEST_LSB    (4),
      .INIT_CYCLES (2)
   ) dut (
      .clk       (clk),
      .reset_L   (reset_L),
      .in_empty  (in_empty),
      .in_data   (in_data),
      .out_pause (out_pause),
      .out_full  (out_full),
      .pop       (pop),
      .push      (push),
      .data_out  (data_out),
      .state     (state),
      .idle      (idle),
      .error     (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            due;
      logic [NQ-1:0] push;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] mem [NQ][16];
   int            wr [NQ];
   int            rp [NQ];
   logic [DW-1:0] rd [NQ];
   logic [DW-1:0] last_data = '0;
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;

   // Empty looks ahead over a pop already presented, as a FIFO with current status would
   function automatic void refresh();
      for (int i = 0; i < NQ; i++) begin
         int sz;
         sz = wr[i] - rp[i];
         in_empty[i] = (sz == 0) || (sz == 1 && pop[i]);
         in_data[i*DW +: DW] = rd[i];
      end
   endfunction

   function automatic void clear_model();
      for (int i = 0; i < NQ; i++) begin
         wr[i] = 0;
         rp[i] = 0;
         rd[i] = '0;
      end
      sb.delete();
      last_data = '0;
      refresh();
   endfunction

   task automatic load(input int q, input logic [DW-1:0] w);
      mem[q][wr[q] % 16] = w;
      wr[q]++;
      refresh();
   endtask

   task automatic tick();
      logic [NQ-1:0] p;
      logic [DW-1:0] w;
      logic [1:0]    d;
      exp_t          e;
      int            g;
      p = pop;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NQ; i++) begin
         if (p[i] && wr[i] != rp[i]) begin
            rd[i] = mem[i][rp[i] % 16];
            rp[i]++;
         end
      end
      checks++;
      if (sb.size() != 0 && sb[0].due == cyc) begin
         if (push !== sb[0].push || data_out !== sb[0].data) begin
            errors++;
            $display("FAIL push_data cyc %0d: push=%b data_out=%h, expected push=%b data_out=%h",
                     cyc, push, data_out, sb[0].push, sb[0].data);
         end
         last_data = sb[0].data;
         sb.delete(0);
      end else if (push !== '0 || data_out !== last_data) begin
         errors++;
         $display("FAIL no_push cyc %0d: push=%b data_out=%h, expected push=0000 data_out=%h",
                  cyc, push, data_out, last_data);
      end
      if (pop !== '0) begin
         checks++;
         g = 0;
         for (int i = 0; i < NQ; i++) if (pop[i] === 1'b1) g = i;
         if ($countones(pop) != 1 || wr[g] == rp[g]) begin
            errors++;
            $display("FAIL pop_valid cyc %0d: pop=%b in_empty=%b, expected one-hot pop of a non-empty queue",
                     cyc, pop, in_empty);
         end else begin
            w = mem[g][rp[g] % 16];
            d = w[5:4];
            e.due  = cyc + 2;
            e.push = 4'b0001 << d;
            e.data = w;
            sb.push_back(e);
         end
      end
      refresh();
   endtask

   task automatic wait_pop(input int bound);
      int n;
      n = 0;
      while (pop === '0 && n < bound) begin
         tick();
         n++;
      end
      if (pop === '0) begin
         checks++;
         errors++;
         $display("FAIL wait_pop: no pop within %0d cycles, expected a grant", bound);
      end
   endtask

   task automatic wait_idle(input int bound);
      int  n;
      logic busy;
      n = 0;
      busy = 1'b1;
      while (busy && n < bound) begin
         tick();
         n++;
         busy = (sb.size() != 0) || (state !== 2'd1);
         for (int i = 0; i < NQ; i++) if (wr[i] != rp[i]) busy = 1'b1;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL wait_idle: state=%0d pending=%0d after %0d cycles, expected state=1 drained",
                  state, sb.size(), bound);
      end
   endtask

   task automatic apply_reset();
      reset_L = 1'b0;
      #1;
      clear_model();
      tick();
      tick();
      reset_L = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_reset();
      reset_L = 1'b0;
      clear_model();
      tick();
      tick();
      checks++;
      if (pop !== '0 || push !== '0 || data_out !== '0 || state !== 2'd0 || idle !== 1'b0 || error !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: pop=%b push=%b data_out=%h state=%0d idle=%b error=%b, expected all 0",
                  pop, push, data_out, state, idle, error);
      end
      reset_L = 1'b1;
      tick();
      checks++;
      if (state !== 2'd0) begin
         errors++;
         $display("FAIL init_hold: state=%0d, expected 0", state);
      end
      tick();
      checks++;
      if (state !== 2'd1 || idle !== 1'b1) begin
         errors++;
         $display("FAIL init_exit: state=%0d idle=%b, expected state=1 idle=1", state, idle);
      end
   endtask

   task automatic test_reset_mid();
      load(1, 6'b10_0111);
      wait_pop(10);
      checks++;
      if (pop !== 4'b0010) begin
         errors++;
         $display("FAIL mid_pop: pop=%b, expected 0010", pop);
      end
      tick();
      reset_L = 1'b0;
      #1;
      checks++;
      if (pop !== '0 || push !== '0 || state !== 2'd0) begin
         errors++;
         $display("FAIL mid_reset: pop=%b push=%b state=%0d, expected 0000 0000 0", pop, push, state);
      end
      clear_model();
      tick();
      reset_L = 1'b1;
      tick();
      checks++;
      if (state !== 2'd0) begin
         errors++;
         $display("FAIL mid_init: state=%0d, expected 0", state);
      end
      tick();
      checks++;
      if (state !== 2'd1) begin
         errors++;
         $display("FAIL mid_idle: state=%0d, expected 1", state);
      end
      repeat (3) tick();
   endtask

   task automatic test_single_drain();
      load(2, 6'b01_0101);
      checks++;
      if (in_empty !== 4'b1011) begin
         errors++;
         $display("FAIL single_empty: in_empty=%b, expected 1011", in_empty);
      end
      wait_pop(10);
      checks++;
      if (pop !== 4'b0100) begin
         errors++;
         $display("FAIL single_pop: pop=%b, expected 0100", pop);
      end
      tick();
      tick();
      checks++;
      if (push !== 4'b0010 || data_out !== 6'h15) begin
         errors++;
         $display("FAIL single_push: push=%b data_out=%h, expected 0010 15", push, data_out);
      end
      tick();
      checks++;
      if (state !== 2'd1 || idle !== 1'b1 || data_out !== 6'h15) begin
         errors++;
         $display("FAIL drain_idle: state=%0d idle=%b data_out=%h, expected 1 1 15", state, idle, data_out);
      end
   endtask

   task automatic test_fairness();
      int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      logic [NQ-1:0] want;
      apply_reset();
      for (int r = 0; r < 2; r++)
         for (int q = 0; q < NQ; q++) load(q, 6'($urandom));
      wait_pop(10);
      for (int k = 0; k < 8; k++) begin
         want = 4'b0001 << order[k];
         checks++;
         if (pop !== want) begin
            errors++;
            $display("FAIL fair_pop%0d: pop=%b, expected %b", k, pop, want);
         end
         tick();
      end
      wait_idle(30);
   endtask

   task automatic test_pause();
      apply_reset();
      for (int r = 0; r < 3; r++)
         for (int q = 0; q < NQ; q++) load(q, 6'($urandom));
      wait_pop(10);
      checks++;
      if (pop !== 4'b0001) begin
         errors++;
         $display("FAIL pause_pop0: pop=%b, expected 0001", pop);
      end
      tick();
      checks++;
      if (pop !== 4'b0010) begin
         errors++;
         $display("FAIL pause_pop1: pop=%b, expected 0010", pop);
      end
      out_pause = 4'b1000;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (state !== 2'd3 || pop !== '0) begin
            errors++;
            $display("FAIL pause_hold%0d: state=%0d pop=%b, expected 3 0000", k, state, pop);
         end
      end
      out_pause = '0;
      tick();
      checks++;
      if (state !== 2'd2 || pop !== '0) begin
         errors++;
         $display("FAIL pause_exit: state=%0d pop=%b, expected 2 0000", state, pop);
      end
      tick();
      checks++;
      if (pop !== 4'b0100) begin
         errors++;
         $display("FAIL pause_resume: pop=%b, expected 0100", pop);
      end
      wait_idle(60);
   endtask

   task automatic test_overflow();
      int n;
      checks++;
      if (error !== 1'b0) begin
         errors++;
         $display("FAIL ovf_pre: error=%b, expected 0", error);
      end
      out_full = 4'b0001;
      load(3, 6'b00_1010);
      n = 0;
      while (push === '0 && n < 12) begin
         tick();
         n++;
      end
      checks++;
      if (push !== 4'b0001 || error !== 1'b1) begin
         errors++;
         $display("FAIL ovf_push: push=%b error=%b, expected 0001 1", push, error);
      end
      out_full = '0;
      load(0, 6'b11_0001);
      wait_idle(30);
      checks++;
      if (error !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: error=%b, expected 1", error);
      end
      apply_reset();
      checks++;
      if (error !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: error=%b, expected 0", error);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid();
      test_single_drain();
      test_fairness();
      test_pause();
      test_overflow();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
